// File: rtl/nrs_pkg.sv
// Shared types and constants for the NRS c_init scheduler.
// Holds the FSM state encoding and the per-subframe NRS symbol layout.
package nrs_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_PUSH,
    ST_DONE
  } state_e;

  localparam int WIDTH_CINIT     = 28;
  localparam int NRS_L0          = 5;
  localparam int NRS_L1          = 6;
  localparam int MAX_SUBFRAME    = 9;
  localparam int SLOTS_PER_SF    = 2;
  localparam int NRS_SYMS_PER_SF = 4;

  // ns of the first or second slot of subframe sf
  function automatic logic [4:0] slot_of(input logic [3:0] sf, input logic second_half);
    return 5'(sf) * 5'(SLOTS_PER_SF) + 5'(second_half);
  endfunction

endpackage

// File: rtl/cinit_watchdog.sv
// Generator-response watchdog: counts enabled cycles since the last clear.
// expire_o is combinational and fires on the TIMEOUT-th enabled cycle.
module cinit_watchdog #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  logic [CNT_W-1:0] cnt_q;

  assign expire_o = en_i && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !expire_o) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/nrs_cinit_scheduler.sv
// Runs the c_init generator four times per subframe (ns=2sf/2sf+1, l=5/6) and
// hands each result downstream over valid/ready; one run and one word in flight.
module nrs_cinit_scheduler
  import nrs_pkg::state_e, nrs_pkg::ST_IDLE, nrs_pkg::ST_ISSUE, nrs_pkg::ST_WAIT,
         nrs_pkg::ST_PUSH, nrs_pkg::ST_DONE, nrs_pkg::MAX_SUBFRAME,
         nrs_pkg::NRS_SYMS_PER_SF, nrs_pkg::slot_of;
#(
  parameter int WIDTH_CINIT = nrs_pkg::WIDTH_CINIT,
  parameter int WIDTH_ID    = 9,
  parameter int TIMEOUT     = 64,
  parameter int CNT_W       = 7,
  parameter int NRS_L0      = nrs_pkg::NRS_L0,
  parameter int NRS_L1      = nrs_pkg::NRS_L1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [3:0]             subframe,
  input  logic [WIDTH_ID-1:0]    N_cell_ID,
  output logic                   gen_run,
  output logic [WIDTH_ID-1:0]    gen_N_cell_ID,
  output logic [4:0]             gen_slot,
  output logic [2:0]             gen_l,
  input  logic                   gen_valid,
  input  logic [WIDTH_CINIT-1:0] gen_cinit,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH_CINIT-1:0] out_cinit,
  output logic [4:0]             out_slot,
  output logic [2:0]             out_l,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  state_e                 state_q, state_d;
  logic [1:0]             idx_q, idx_d;
  logic [3:0]             sf_q, sf_d;
  logic [WIDTH_ID-1:0]    id_q, id_d;
  logic                   gen_run_q, gen_run_d;
  logic [4:0]             gen_slot_q, gen_slot_d;
  logic [2:0]             gen_l_q, gen_l_d;
  logic                   out_valid_q, out_valid_d;
  logic [WIDTH_CINIT-1:0] out_cinit_q, out_cinit_d;
  logic [4:0]             out_slot_q, out_slot_d;
  logic [2:0]             out_l_q, out_l_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic sf_ok;
  logic last_word;
  logic wd_expire;

  assign sf_ok     = (subframe <= 4'(MAX_SUBFRAME));
  assign last_word = (idx_q == 2'(NRS_SYMS_PER_SF - 1));

  cinit_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (state_q == ST_ISSUE),
    .en_i     ((state_q == ST_WAIT) && !gen_valid),
    .expire_o (wd_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start && sf_ok) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (gen_valid)      state_d = ST_PUSH;
        else if (wd_expire) state_d = ST_IDLE;
      end
      ST_PUSH:  if (out_ready) state_d = last_word ? ST_DONE : ST_ISSUE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs are computed from the upcoming state so every port comes straight off a flop.
  always_comb begin
    idx_d       = idx_q;
    sf_d        = sf_q;
    id_d        = id_q;
    gen_run_d   = 1'b0;
    gen_slot_d  = gen_slot_q;
    gen_l_d     = gen_l_q;
    out_valid_d = out_valid_q;
    out_cinit_d = out_cinit_q;
    out_slot_d  = out_slot_q;
    out_l_d     = out_l_q;
    err_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (sf_ok) begin
            sf_d  = subframe;
            id_d  = N_cell_ID;
            idx_d = 2'd0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (gen_valid) begin
          out_valid_d = 1'b1;
          out_cinit_d = gen_cinit;
          out_slot_d  = gen_slot_q;
          out_l_d     = gen_l_q;
        end else if (wd_expire) begin
          err_d = 1'b1;
        end
      end
      ST_PUSH: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (!last_word) idx_d = idx_q + 2'd1;
        end
      end
      default: ;
    endcase
    if (state_d == ST_ISSUE) begin
      gen_run_d  = 1'b1;
      gen_slot_d = slot_of(sf_d, idx_d[1]);
      gen_l_d    = idx_d[0] ? 3'(NRS_L1) : 3'(NRS_L0);
    end
    busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q       <= '0;
      sf_q        <= '0;
      id_q        <= '0;
      gen_run_q   <= 1'b0;
      gen_slot_q  <= '0;
      gen_l_q     <= '0;
      out_valid_q <= 1'b0;
      out_cinit_q <= '0;
      out_slot_q  <= '0;
      out_l_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      sf_q        <= sf_d;
      id_q        <= id_d;
      gen_run_q   <= gen_run_d;
      gen_slot_q  <= gen_slot_d;
      gen_l_q     <= gen_l_d;
      out_valid_q <= out_valid_d;
      out_cinit_q <= out_cinit_d;
      out_slot_q  <= out_slot_d;
      out_l_q     <= out_l_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign gen_run       = gen_run_q;
  assign gen_N_cell_ID = id_q;
  assign gen_slot      = gen_slot_q;
  assign gen_l         = gen_l_q;
  assign out_valid     = out_valid_q;
  assign out_cinit     = out_cinit_q;
  assign out_slot      = out_slot_q;
  assign out_l         = out_l_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_nrs_cinit_scheduler.sv
// Bench for nrs_cinit_scheduler: behavioural generator with programmable latency,
// a scoreboard of expected runs/words built from the NRS c_init formula, and timing checks.
module tb_nrs_cinit_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  subframe = '0;
  logic [8:0]  N_cell_ID = '0;
  logic        gen_valid = 1'b0;
  logic [27:0] gen_cinit = '0;
  logic        out_ready = 1'b1;

  logic        gen_run, out_valid, busy, done, err;
  logic [8:0]  gen_N_cell_ID;
  logic [4:0]  gen_slot, out_slot;
  logic [2:0]  gen_l, out_l;
  logic [27:0] out_cinit;
  logic [57:0] all_outs;

  assign all_outs = {gen_run, busy, done, err, out_valid, gen_slot, gen_l, gen_N_cell_ID,
                     out_cinit, out_slot, out_l};

  nrs_cinit_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .subframe      (subframe),
    .N_cell_ID     (N_cell_ID),
    .gen_run       (gen_run),
    .gen_N_cell_ID (gen_N_cell_ID),
    .gen_slot      (gen_slot),
    .gen_l         (gen_l),
    .gen_valid     (gen_valid),
    .gen_cinit     (gen_cinit),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_cinit     (out_cinit),
    .out_slot      (out_slot),
    .out_l         (out_l),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [27:0] golden(input int ns, input int l, input int id);
    logic [63:0] v;
    v = 64'(1024 * (7 * (ns + 1) + l + 1)) * 64'(2 * id + 1) + 64'(2 * id + 1);
    return v[27:0];
  endfunction

  typedef struct {
    int          slot;
    int          l;
    int          id;
    logic [27:0] cinit;
  } word_t;

  word_t exp_run[$];
  word_t exp_out[$];
  word_t mon_e;

  // Generator model: answers gen_run after gen_lat cycles unless gen_dead.
  int gen_lat  = 5;
  bit gen_dead = 1'b0;
  int gcnt = 0;
  int g_slot, g_l, g_id;

  always @(negedge clk) begin
    if (rst) begin
      gcnt      = 0;
      gen_valid = 1'b0;
    end else begin
      gen_valid = 1'b0;
      if (gcnt > 0) begin
        gcnt--;
        if (gcnt == 0) begin
          gen_valid = 1'b1;
          gen_cinit = golden(g_slot, g_l, g_id);
        end
      end
      if (gen_run && !gen_dead) begin
        gcnt   = gen_lat;
        g_slot = int'(gen_slot);
        g_l    = int'(gen_l);
        g_id   = int'(gen_N_cell_ID);
      end
    end
  end

  bit ready_rand = 1'b0;
  always @(posedge clk) begin
    #1;
    if (ready_rand) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor / scoreboard
  int run_cnt = 0, hs_cnt = 0, ov_cnt = 0, done_cnt = 0, err_cnt = 0;
  int done_cyc = 0, err_cyc = 0, first_run_cyc = -1;
  bit first_hs_seen = 1'b0;
  logic [27:0] first_hs_cinit = '0;
  bit prev_stall = 1'b0;
  logic [35:0] prev_dat = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_vld", out_valid, 1);
        chk("hold_dat", {out_slot, out_l, out_cinit}, prev_dat);
      end
      prev_stall = out_valid && !out_ready;
      prev_dat   = {out_slot, out_l, out_cinit};
      if (gen_run) begin
        run_cnt++;
        if (first_run_cyc < 0) first_run_cyc = cyc;
        chk("run_expected", exp_run.size() > 0, 1);
        if (exp_run.size() > 0) begin
          mon_e = exp_run.pop_front();
          chk("gen_slot", gen_slot, mon_e.slot);
          chk("gen_l", gen_l, mon_e.l);
          chk("gen_id", gen_N_cell_ID, mon_e.id);
        end
        chk("run_while_valid", out_valid, 0);
      end
      if (out_valid) ov_cnt++;
      if (out_valid && out_ready) begin
        hs_cnt++;
        chk("word_expected", exp_out.size() > 0, 1);
        if (exp_out.size() > 0) begin
          mon_e = exp_out.pop_front();
          chk("out_cinit", out_cinit, mon_e.cinit);
          chk("out_slot", out_slot, mon_e.slot);
          chk("out_l", out_l, mon_e.l);
        end
        if (!first_hs_seen) begin
          first_hs_seen  = 1'b1;
          first_hs_cinit = out_cinit;
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("busy_at_done", busy, 0);
      end
      if (err) begin
        err_cnt++;
        err_cyc = cyc;
      end
    end
  end

  int start_cyc, run_base, hs_base, ov_base, done_base, err_base;

  task automatic kick(input int sf, input int id);
    word_t w;
    @(posedge clk);
    #1;
    start         = 1'b1;
    subframe      = 4'(sf);
    N_cell_ID     = 9'(id);
    start_cyc     = cyc;
    first_run_cyc = -1;
    first_hs_seen = 1'b0;
    run_base      = run_cnt;
    hs_base       = hs_cnt;
    ov_base       = ov_cnt;
    done_base     = done_cnt;
    err_base      = err_cnt;
    if (sf <= 9) begin
      for (int i = 0; i < 4; i++) begin
        w.slot  = 2 * sf + i / 2;
        w.l     = (i % 2 == 1) ? 6 : 5;
        w.id    = id;
        w.cinit = golden(w.slot, w.l, id);
        exp_run.push_back(w);
        exp_out.push_back(w);
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int bound);
    int n = 0;
    while (done_cnt == done_base && n < bound) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_done_once"}, done_cnt - done_base, 1);
    @(negedge clk);
    chk({tag, "_sb_empty"}, exp_out.size() + exp_run.size(), 0);
    chk({tag, "_words"}, hs_cnt - hs_base, 4);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int n;
    int rb, db, eb;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", all_outs, 0);
    rst = 1'b0;

    // Basic sequence, latency 5, ready high
    gen_lat = 5;
    kick(0, 0);
    wait_done("t1", 300);
    chk("t1_first_run_lat", first_run_cyc - start_cyc, 1);
    chk("t1_first_cinit", first_hs_cinit, 13313);
    chk("t1_done_cyc", done_cyc - start_cyc, 29);
    chk("t1_runs", run_cnt - run_base, 4);

    // Last subframe, max cell ID
    gen_lat = 3;
    kick(9, 503);
    wait_done("t2", 300);
    chk("t2_done_cyc", done_cyc - start_cyc, 21);

    // Backpressure on the second word
    gen_lat = 2;
    kick(4, 77);
    n = 0;
    while (hs_cnt - hs_base < 1 && n < 100) begin @(posedge clk); #1; n++; end
    chk("t3_first_word", hs_cnt - hs_base, 1);
    out_ready = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    chk("t3_word2_valid", out_valid, 1);
    rb = run_cnt;
    repeat (6) @(posedge clk);
    #1;
    chk("t3_valid_held", out_valid, 1);
    chk("t3_no_run_stall", run_cnt, rb);
    out_ready = 1'b1;
    wait_done("t3", 300);

    // Dead generator: watchdog abort
    gen_dead = 1'b1;
    kick(2, 10);
    n = 0;
    while (err_cnt == err_base && n < 200) begin @(posedge clk); #1; n++; end
    chk("t4_err_once", err_cnt - err_base, 1);
    chk("t4_err_cyc", err_cyc - start_cyc, 66);
    chk("t4_busy_low", busy, 0);
    chk("t4_no_valid", ov_cnt - ov_base, 0);
    chk("t4_runs", run_cnt - run_base, 1);
    chk("t4_no_done", done_cnt - done_base, 0);
    exp_run.delete();
    exp_out.delete();
    gen_dead = 1'b0;
    gen_lat  = 4;
    kick(5, 200);
    wait_done("t4b", 300);

    // Invalid subframe
    kick(12, 33);
    repeat (3) @(posedge clk);
    #1;
    chk("t5_err_once", err_cnt - err_base, 1);
    chk("t5_err_cyc", err_cyc - start_cyc, 1);
    chk("t5_no_run", run_cnt - run_base, 0);
    chk("t5_busy", busy, 0);

    // start while busy is ignored
    gen_lat = 4;
    kick(3, 100);
    @(posedge clk);
    #1;
    start     = 1'b1;
    subframe  = 4'd7;
    N_cell_ID = 9'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("t5b", 300);
    chk("t5b_runs", run_cnt - run_base, 4);

    // Reset mid-WAIT
    gen_lat = 20;
    kick(6, 300);
    repeat (4) @(posedge clk);
    #3;
    db  = done_cnt;
    eb  = err_cnt;
    rst = 1'b1;
    #1;
    chk("t6_rst_outs", all_outs, 0);
    exp_run.delete();
    exp_out.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("t6_no_done_err", {done_cnt - db, err_cnt - eb}, 0);
    gen_lat = 5;
    kick(1, 50);
    wait_done("t6b", 300);

    // Randomized runs with random backpressure
    ready_rand = 1'b1;
    for (int i = 0; i < 8; i++) begin
      gen_lat = $urandom_range(1, 8);
      kick($urandom_range(0, 9), $urandom_range(0, 503));
      wait_done("rnd", 1000);
    end
    ready_rand = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    chk("final_no_err", err_cnt, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
